md_unit_ctrl: RTL and testbench

Multiply/divide unit controller for the 5-stage MIPS pipeline. Accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` issued from the E stage and sequences the multi-cycle operation with a latency counter. Owns the HI/LO registers and drives the busy flag. Generates the D-stage stall request that keeps any later mult/div-class instruction out of E until the unit is free.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_arith.sv | 54 +++++
 rtl/md_unit_ctrl.sv | 81 ++++++++
 tb/tb_md_unit_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encoding and class predicates.
// Used by the E-stage decoder and the md unit. No logic of its own.
// No state, so no backpressure applies.
package md_pkg;

    localparam int MD_OP_W = 3;
    typedef logic [MD_OP_W-1:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    function automatic logic is_mult_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath: 64-bit {hi,lo} result plus divide-by-zero flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the controller decides when the result is captured.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        dz
);

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [63:0] ext_a;
    logic [63:0] ext_b;

    // Signedness only matters for operand extension and divide sign fix-up.
    assign sgn   = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg = sgn & a[31];
    assign b_neg = sgn & b[31];

    // Low 64 bits of the 64x64 product are the exact 32x32 product for either signedness.
    assign ext_a = {{32{a_neg}}, a};
    assign ext_b = {{32{b_neg}}, b};

    // Divide on magnitudes so INT_MIN / -1 never overflows a signed divider.
    assign mag_a = a_neg ? (32'd0 - a) : a;
    assign mag_b = b_neg ? (32'd0 - b) : b;
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uq    = mag_a / div_b;
    assign ur    = mag_a % div_b;

    // Select the result; quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        res = 64'd0;
        dz  = 1'b0;
        if (is_mult_op(op)) begin
            res = ext_a * ext_b;
        end else if (is_div_op(op)) begin
            dz  = (b == 32'd0);
            res = {(a_neg ? (32'd0 - ur) : ur),
                   ((a_neg ^ b_neg) ? (32'd0 - uq) : uq)};
        end
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// MIPS mult/div controller: latency counter, pending result, HI/LO, D-stage stall.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; mthi/mtlo one edge.
// Backpressure: start ignored while busy; stall holds later md-class ops in D.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_dz;
    logic [63:0]   arith_res;
    logic          arith_dz;
    logic          op_md;

    md_arith u_arith (
        .op  (md_op),
        .a   (rs_val),
        .b   (rt_val),
        .res (arith_res),
        .dz  (arith_dz)
    );

    assign op_md = is_mult_op(md_op) | is_div_op(md_op);

    // Stall reacts to the E-stage start in the same cycle; the busy term is registered.
    assign stall = d_is_md & (busy | (start & op_md));

    // Counter sequencing, operand-result capture, commit and HI/LO moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            busy    <= 1'b0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (!pend_dz) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (start) begin
            if (op_md) begin
                pend_hi <= arith_res[63:32];
                pend_lo <= arith_res[31:0];
                pend_dz <= arith_dz;
                cnt     <= is_mult_op(md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                busy    <= 1'b1;
            end else if (md_op == MD_MTHI) begin
                hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: vector table, corner sequences, random vs model.
// Latency: inputs driven on the falling edge, outputs checked 1 ns later.
// Backpressure: busy waits are bounded by a cycle budget.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .d_is_md (d_is_md),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd);
        @(negedge clk);
        start = s; md_op = op; rs_val = a; rt_val = b; d_is_md = dmd;
        #1;
    endtask

    // Reference arithmetic from the instruction definitions: {dz, hi, lo}.
    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, sp, q, r;
        longint unsigned ua, ub, up;
        logic [64:0]     o;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        o  = '0;
        case (op)
            3'd1: begin sp = sa * sb; o = {1'b0, sp[63:0]}; end
            3'd2: begin up = ua * ub; o = {1'b0, up[63:0]}; end
            3'd3: if (b == 0) o[64] = 1'b1;
                  else begin q = sa / sb; r = sa % sb; o = {1'b0, r[31:0], q[31:0]}; end
            3'd4: if (b == 0) o[64] = 1'b1;
                  else begin up = ua / ub; q = longint'(ua % ub);
                             o = {1'b0, q[31:0], up[31:0]}; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Behavioural model state.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_dz;
    int          m_left;

    task automatic model_step(input logic s, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        logic [64:0] r;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_dz) {m_hi, m_lo} = m_res;
        end else if (s) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                r      = ref_op(op, a, b);
                m_dz   = r[64];
                m_res  = r[63:0];
                m_left = (op <= 3'd2) ? 5 : 10;
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6)     m_lo = a;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vt[10];

    initial begin
        int cyc;
        logic s, dmd, es;
        logic [2:0] op;
        logic [31:0] a, b;

        reset = 1'b0; start = 1'b0; md_op = MD_NONE; rs_val = 0; rt_val = 0; d_is_md = 1'b0;

        // Reset held for three cycles with random inputs.
        for (int i = 0; i < 3; i++)
            drive(1'($urandom), 3'($urandom), $urandom, $urandom, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); reset = 1'b1;

        vt[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3] = '{MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[4] = '{MD_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
        vt[5] = '{MD_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        vt[6] = '{MD_NONE,  32'hDEADBEEF, 32'd5,        32'h12345678, 32'h9ABCDEF0, 0};
        vt[7] = '{3'd7,     32'hDEADBEEF, 32'd5,        32'h12345678, 32'h9ABCDEF0, 0};
        vt[8] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[9] = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};

        foreach (vt[i]) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b0);
            cyc = 0;
            drive(1'b0, MD_NONE, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
            while (busy && cyc < 40) begin
                cyc++;
                drive(1'b0, MD_NONE, $urandom, $urandom, 1'b0);
            end
            chk($sformatf("vec%0d_busy_cycles", i), cyc, vt[i].exp_cyc);
            chk($sformatf("vec%0d_hi", i), hi, vt[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vt[i].exp_lo);
        end

        // Stall window, with an ignored start during busy.
        drive(1'b1, MD_MULT, 32'd5, 32'd6, 1'b1);
        chk("stall_start_cycle", {31'd0, stall}, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            drive(i == 2, MD_DIVU, 32'd100, 32'd3, 1'b1);
            chk($sformatf("stall_busy%0d", i), {31'd0, stall}, 32'd1);
            chk($sformatf("busy_win%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("hold_lo%0d", i), lo, 32'h0000000E);
        end
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
        chk("stall_after", {31'd0, stall}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("win_hi", hi, 32'd0);
        chk("win_lo", lo, 32'd30);
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
        chk("ignored_start_no_busy", {31'd0, busy}, 32'd0);

        // Move-to on consecutive cycles.
        drive(1'b1, MD_MTHI, 32'h12345678, 32'd0, 1'b0);
        drive(1'b1, MD_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_unchanged", lo, 32'd30);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_unchanged", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // Reset in the third busy cycle of a divide.
        drive(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk); reset = 1'b0; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 14; i++) drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd333 - 32'd333);

        // Random traffic against the model, starting from reset.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m_hi = 0; m_lo = 0; m_res = 0; m_dz = 0; m_left = 0;
        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom_range(0, 2) == 0);
            op  = 3'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            dmd = 1'($urandom);
            drive(s, op, a, b, dmd);
            es = dmd && (m_left > 0 || (s && op >= 3'd1 && op <= 3'd4));
            chk("rnd_busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);
            chk("rnd_stall", {31'd0, stall}, {31'd0, es});
            model_step(s, op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
